// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle MIPS control unit sequencing fetch/decode/execute/mem/wb
//   Optional feature macro: CTRL_BNE_EN (adds bne, opcode 000101, taken on ~zero)
//   Ports: clk, reset (async, active-high); opcode (sampled in DECODE), zero, mem_ready in;
//   ir_write, pc_write, pc_src, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
//   alu_src_a, alu_src_b, alu_op datapath controls; state (debug), illegal (sticky), retired count out.
module multicycle_control_fsm #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int RET_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [3:0]          state,
    output logic                illegal,
    output logic [RET_W-1:0]    retired
);
    typedef enum logic [3:0] {
        fetch = 4'd0, decode = 4'd1, mem_addr = 4'd2, mem_rd = 4'd3, mem_wb = 4'd4,
        mem_wr = 4'd5, exec_r = 4'd6, r_wb = 4'd7, branch = 4'd8, jump = 4'd9,
        exec_i = 4'd10, i_wb = 4'd11, trap = 4'd12
    } state_t;
    localparam logic [OPCODE_W-1:0] op_r    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] op_j    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] op_beq  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] op_addi = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] op_slti = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] op_andi = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] op_ori  = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] op_lw   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] op_sw   = OPCODE_W'(6'b101011);
`ifdef CTRL_BNE_EN
    localparam logic [OPCODE_W-1:0] op_bne  = OPCODE_W'(6'b000101);
`endif
    localparam logic [ALUOP_W-1:0] alu_add = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] alu_slt = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] alu_fn  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] alu_and = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] alu_or  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] alu_sub = ALUOP_W'(5);
    state_t cur, nxt;
    logic [OPCODE_W-1:0] op;
    assign state = cur;
    always_comb begin
        nxt = cur;
        case (cur)
            fetch:    nxt = mem_ready ? decode : fetch;
            decode:
                case (opcode)
                    op_r:                             nxt = exec_r;
                    op_addi, op_slti, op_andi, op_ori: nxt = exec_i;
                    op_lw, op_sw:                     nxt = mem_addr;
                    op_beq:                           nxt = branch;
`ifdef CTRL_BNE_EN
                    op_bne:                           nxt = branch;
`endif
                    op_j:                             nxt = jump;
                    default:                          nxt = trap;
                endcase
            exec_r:   nxt = r_wb;
            exec_i:   nxt = i_wb;
            mem_addr: nxt = (op == op_lw) ? mem_rd : mem_wr;
            mem_rd:   nxt = mem_ready ? mem_wb : mem_rd;
            mem_wr:   nxt = mem_ready ? fetch : mem_wr;
            r_wb, i_wb, mem_wb, branch, jump: nxt = fetch;
            trap:     nxt = trap;
            default:  nxt = trap;
        endcase
    end
    // Outputs decode the current state; reset forces them low so no strobe fires while aborting.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = alu_add;
        if (!reset) begin
            case (cur)
                fetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                decode:   alu_src_b = 2'b11;
                exec_r: begin
                    alu_src_a = 1'b1;
                    alu_op    = alu_fn;
                end
                r_wb: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                exec_i: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (op == op_slti) ? alu_slt : (op == op_andi) ? alu_and :
                                (op == op_ori) ? alu_or : alu_add;
                end
                i_wb:     reg_write = 1'b1;
                mem_addr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                mem_rd: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                mem_wb: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                mem_wr: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                branch: begin
                    alu_src_a = 1'b1;
                    alu_op    = alu_sub;
                    pc_src    = 2'b01;
`ifdef CTRL_BNE_EN
                    pc_write  = (op == op_bne) ? ~zero : zero;
`else
                    pc_write  = zero;
`endif
                end
                jump: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= fetch;
            op      <= '0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cur == decode) op <= opcode;
            if (nxt == trap) illegal <= 1'b1;
            // Only completing states ever return to fetch, so any re-entry retires one instruction.
            if (nxt == fetch && cur != fetch) retired <= retired + RET_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       ir_write, pc_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b, retired;
  logic [2:0] alu_op;
  logic [3:0] state;
  int checks = 0;
  int failures = 0;
  multicycle_control_fsm #(.OPCODE_W(6), .ALUOP_W(3), .RET_W(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal),
    .retired(retired)
  );
  always #5 clk = ~clk;
  localparam logic [15:0] c_zero = 16'b0;
  localparam logic [15:0] c_fr   = 16'b1_1_00_0_1_0_0_0_0_0_01_000;
  localparam logic [15:0] c_fw   = 16'b0_0_00_0_1_0_0_0_0_0_01_000;
  localparam logic [15:0] c_dec  = 16'b0_0_00_0_0_0_0_0_0_0_11_000;
  localparam logic [15:0] c_exr  = 16'b0_0_00_0_0_0_0_0_0_1_00_010;
  localparam logic [15:0] c_rwb  = 16'b0_0_00_0_0_0_0_1_1_0_00_000;
  localparam logic [15:0] c_addi = 16'b0_0_00_0_0_0_0_0_0_1_10_000;
  localparam logic [15:0] c_slti = 16'b0_0_00_0_0_0_0_0_0_1_10_001;
  localparam logic [15:0] c_andi = 16'b0_0_00_0_0_0_0_0_0_1_10_011;
  localparam logic [15:0] c_ori  = 16'b0_0_00_0_0_0_0_0_0_1_10_100;
  localparam logic [15:0] c_iwb  = 16'b0_0_00_0_0_0_0_0_1_0_00_000;
  localparam logic [15:0] c_madr = 16'b0_0_00_0_0_0_0_0_0_1_10_000;
  localparam logic [15:0] c_mrd  = 16'b0_0_00_1_1_0_0_0_0_0_00_000;
  localparam logic [15:0] c_mwb  = 16'b0_0_00_0_0_0_1_0_1_0_00_000;
  localparam logic [15:0] c_mwr  = 16'b0_0_00_1_0_1_0_0_0_0_00_000;
  localparam logic [15:0] c_br1  = 16'b0_1_01_0_0_0_0_0_0_1_00_101;
  localparam logic [15:0] c_br0  = 16'b0_0_01_0_0_0_0_0_0_1_00_101;
  localparam logic [15:0] c_jmp  = 16'b0_1_10_0_0_0_0_0_0_0_00_000;
  typedef struct {
    string       name;
    logic [22:0] v;
  } exp_t;
  exp_t q[$];
  task automatic cyc(input string n, input logic [3:0] st, input logic [15:0] c, input logic [1:0] r, input logic il);
    exp_t e;
    e.name = n;
    e.v = {st, c, r, il};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [22:0] act;
      e = q.pop_front();
      act = {state, ir_write, pc_write, pc_src, iord, mem_read, mem_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, retired, illegal};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got %b required %b", e.name, act, e.v);
      end
    end
  end
  initial begin
    repeat (2000) @(posedge clk);
    failures++;
    $display("FAIL timeout: wait expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || retired !== 2'd0 || mem_read !== 1'b0 ||
        mem_write !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0 || ir_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: state=%0d illegal=%b retired=%0d", state, illegal, retired);
    end
    cyc("reset0", 4'd0, c_zero, 2'd0, 1'b0);
    cyc("reset1", 4'd0, c_zero, 2'd0, 1'b0);
    reset = 1'b0;
    opcode = 6'b000000;
    cyc("add_fetch", 4'd0, c_fr, 2'd0, 1'b0);
    cyc("add_decode", 4'd1, c_dec, 2'd0, 1'b0);
    cyc("add_exec", 4'd6, c_exr, 2'd0, 1'b0);
    cyc("add_wb", 4'd7, c_rwb, 2'd0, 1'b0);
    opcode = 6'b100011;
    cyc("lw_fetch", 4'd0, c_fr, 2'd1, 1'b0);
    cyc("lw_decode", 4'd1, c_dec, 2'd1, 1'b0);
    cyc("lw_addr", 4'd2, c_madr, 2'd1, 1'b0);
    mem_ready = 1'b0;
    cyc("lw_wait0", 4'd3, c_mrd, 2'd1, 1'b0);
    cyc("lw_wait1", 4'd3, c_mrd, 2'd1, 1'b0);
    mem_ready = 1'b1;
    cyc("lw_read", 4'd3, c_mrd, 2'd1, 1'b0);
    cyc("lw_wb", 4'd4, c_mwb, 2'd1, 1'b0);
    opcode = 6'b000100;
    zero = 1'b1;
    mem_ready = 1'b0;
    cyc("beq_fetch_wait", 4'd0, c_fw, 2'd2, 1'b0);
    mem_ready = 1'b1;
    cyc("beq_fetch", 4'd0, c_fr, 2'd2, 1'b0);
    cyc("beq_decode", 4'd1, c_dec, 2'd2, 1'b0);
    cyc("beq_taken", 4'd8, c_br1, 2'd2, 1'b0);
    zero = 1'b0;
    cyc("beq2_fetch", 4'd0, c_fr, 2'd3, 1'b0);
    cyc("beq2_decode", 4'd1, c_dec, 2'd3, 1'b0);
    cyc("beq_not_taken", 4'd8, c_br0, 2'd3, 1'b0);
    opcode = 6'b001000;
    cyc("addi_fetch_wrap", 4'd0, c_fr, 2'd0, 1'b0);
    cyc("addi_decode", 4'd1, c_dec, 2'd0, 1'b0);
    cyc("addi_exec", 4'd10, c_addi, 2'd0, 1'b0);
    cyc("addi_wb", 4'd11, c_iwb, 2'd0, 1'b0);
    opcode = 6'b001010;
    cyc("slti_fetch", 4'd0, c_fr, 2'd1, 1'b0);
    cyc("slti_decode", 4'd1, c_dec, 2'd1, 1'b0);
    opcode = 6'b111111;
    cyc("slti_exec", 4'd10, c_slti, 2'd1, 1'b0);
    cyc("slti_wb", 4'd11, c_iwb, 2'd1, 1'b0);
    opcode = 6'b001100;
    cyc("andi_fetch", 4'd0, c_fr, 2'd2, 1'b0);
    cyc("andi_decode", 4'd1, c_dec, 2'd2, 1'b0);
    cyc("andi_exec", 4'd10, c_andi, 2'd2, 1'b0);
    cyc("andi_wb", 4'd11, c_iwb, 2'd2, 1'b0);
    opcode = 6'b001101;
    cyc("ori_fetch", 4'd0, c_fr, 2'd3, 1'b0);
    cyc("ori_decode", 4'd1, c_dec, 2'd3, 1'b0);
    cyc("ori_exec", 4'd10, c_ori, 2'd3, 1'b0);
    cyc("ori_wb", 4'd11, c_iwb, 2'd3, 1'b0);
    opcode = 6'b101011;
    cyc("sw_fetch", 4'd0, c_fr, 2'd0, 1'b0);
    cyc("sw_decode", 4'd1, c_dec, 2'd0, 1'b0);
    cyc("sw_addr", 4'd2, c_madr, 2'd0, 1'b0);
    mem_ready = 1'b0;
    cyc("sw_wait", 4'd5, c_mwr, 2'd0, 1'b0);
    mem_ready = 1'b1;
    cyc("sw_write", 4'd5, c_mwr, 2'd0, 1'b0);
    opcode = 6'b000010;
    cyc("j_fetch", 4'd0, c_fr, 2'd1, 1'b0);
    cyc("j_decode", 4'd1, c_dec, 2'd1, 1'b0);
    cyc("j_jump", 4'd9, c_jmp, 2'd1, 1'b0);
    opcode = 6'b101011;
    cyc("sw2_fetch", 4'd0, c_fr, 2'd2, 1'b0);
    cyc("sw2_decode", 4'd1, c_dec, 2'd2, 1'b0);
    cyc("sw2_addr", 4'd2, c_madr, 2'd2, 1'b0);
    mem_ready = 1'b0;
    cyc("sw2_wait", 4'd5, c_mwr, 2'd2, 1'b0);
    reset = 1'b1;
    cyc("sw2_abort", 4'd0, c_zero, 2'd0, 1'b0);
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b000101;
    zero = 1'b0;
    cyc("bne_fetch", 4'd0, c_fr, 2'd0, 1'b0);
    cyc("bne_decode", 4'd1, c_dec, 2'd0, 1'b0);
`ifdef CTRL_BNE_EN
    cyc("bne_taken", 4'd8, c_br1, 2'd0, 1'b0);
    cyc("bne_retire", 4'd0, c_fr, 2'd1, 1'b0);
`else
    cyc("bne_trap", 4'd12, c_zero, 2'd0, 1'b1);
    cyc("bne_trap_hold", 4'd12, c_zero, 2'd0, 1'b1);
`endif
    reset = 1'b1;
    cyc("reset2", 4'd0, c_zero, 2'd0, 1'b0);
    reset = 1'b0;
    opcode = 6'b111111;
    cyc("ill_fetch", 4'd0, c_fr, 2'd0, 1'b0);
    cyc("ill_decode", 4'd1, c_dec, 2'd0, 1'b0);
    cyc("ill_trap", 4'd12, c_zero, 2'd0, 1'b1);
    mem_ready = 1'b0;
    opcode = 6'b000000;
    cyc("ill_hold", 4'd12, c_zero, 2'd0, 1'b1);
    mem_ready = 1'b1;
    cyc("ill_hold2", 4'd12, c_zero, 2'd0, 1'b1);
    reset = 1'b1;
    cyc("ill_reset", 4'd0, c_zero, 2'd0, 1'b0);
    reset = 1'b0;
    cyc("post_fetch", 4'd0, c_fr, 2'd0, 1'b0);
    cyc("post_decode", 4'd1, c_dec, 2'd0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
